mem_burst_arbiter: RTL and testbench

// - Sits between the L2 instruction/data caches in cache_top and the off-chip burst memory port of mp4.
// - Arbitrates whole-line requests from the I-side (read-only) and D-side (read/write).
// - Converts each 256-bit line transfer into a 4-beat 64-bit burst, and returns the assembled line with a one-cycle resp.

---
 rtl/mem_burst_arbiter.sv | 118 +++++++++++
 tb/tb_mem_burst_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_arbiter.sv
// Line-level I/D arbiter that turns whole-line requests into beat bursts on the memory port.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: D over I).
module mem_burst_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BURST_W-1:0] mem_wdata,
  input  logic [BURST_W-1:0] mem_rdata,
  input  logic              mem_resp
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              owner;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wline;
  logic [LINE_W-1:0] rbuf;
  logic              d_req;
  logic              grant_d;
  logic [ADDR_W-1:0] sel_addr;
  logic              last_beat;
  logic              unused_addr_bits;

  assign d_req     = d_read | d_write;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign sel_addr  = grant_d ? d_addr : i_addr;
  assign unused_addr_bits = ^sel_addr[OFF_W-1:0];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  // On a tie the side that was not served most recently wins.
  assign grant_d = d_req & (~i_read | (last_owner == OWN_I));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               last_owner <= OWN_D;
    else if (state == DONE) last_owner <= owner;
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      owner  <= OWN_I;
      addr_q <= '0;
      wline  <= '0;
      rbuf   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req | i_read) begin
            owner  <= grant_d ? OWN_D : OWN_I;
            addr_q <= {sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wline  <= d_wdata;
            // A write request wins over a simultaneous read from the D-side.
            state  <= (grant_d & d_write) ? WRITE : READ;
          end
        end
        READ: begin
          if (mem_resp) begin
            rbuf[cnt*BURST_W +: BURST_W] <= mem_rdata;
            if (last_beat) state <= DONE;
            else           cnt   <= cnt + 1'b1;
          end
        end
        WRITE: begin
          if (mem_resp) begin
            if (last_beat) state <= DONE;
            else           cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_read    = (state == READ);
  assign mem_write   = (state == WRITE);
  assign mem_address = addr_q;
  assign mem_wdata   = (state == WRITE) ? wline[cnt*BURST_W +: BURST_W] : '0;
  assign i_resp      = (state == DONE) & (owner == OWN_I);
  assign d_resp      = (state == DONE) & (owner == OWN_D);
  assign i_rdata     = i_resp ? rbuf : '0;
  assign d_rdata     = d_resp ? rbuf : '0;
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench for mem_burst_arbiter: line-level reference memory vs. a beat-level memory device.
module tb_mem_burst_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_read = 1'b0;
  logic [31:0]  i_addr = '0;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [31:0]  d_addr = '0;
  logic [255:0] d_wdata = '0;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata = '0;
  logic         mem_resp = 1'b0;

  mem_burst_arbiter #(.ADDR_W(32), .LINE_W(256), .BURST_W(64)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
    bit           wr;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t i_q[$];
  exp_t d_q[$];
  int served_q[$];
  logic [255:0] ref_mem [logic [31:0]];
  logic [255:0] dev_mem [logic [31:0]];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input bit ok, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 4; k++) l[64*k +: 64] = {a ^ 32'hA5A5_0000 ^ 32'(k), ~a + 32'(k * 7)};
    return l;
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic logic [255:0] dev_line(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_line(a);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  // Beat-level memory device: programmable wait states, optional spurious resp while idle.
  int fixed_wait = 0;
  bit spur_rand = 0;
  bit spur_all = 0;
  bit dev_active = 0;
  int dev_beat = 0, dev_wcnt = 0, dev_wait = 0, dev_len = 0, dev_last_len = 0;
  logic [31:0]  dev_last_addr = '0;
  logic [255:0] dev_wbuf = '0;

  function automatic int pick_wait();
    return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
  endfunction

  always @(negedge clk) begin
    logic [255:0] tl;
    mem_resp = 1'b0;
    if (mem_read | mem_write) begin
      if (!dev_active) begin
        dev_active = 1; dev_beat = 0; dev_wcnt = 0; dev_len = 0;
        dev_wait = pick_wait(); dev_last_addr = mem_address;
      end
      dev_len++;
      if (dev_wcnt < dev_wait) dev_wcnt++;
      else if (dev_beat < 4) begin
        mem_resp = 1'b1;
        dev_wcnt = 0;
        dev_wait = pick_wait();
        if (mem_read) begin
          tl = dev_line(mem_address);
          mem_rdata = tl[64*dev_beat +: 64];
        end else dev_wbuf[64*dev_beat +: 64] = mem_wdata;
        dev_beat++;
        if (mem_write && dev_beat == 4) dev_mem[mem_address] = dev_wbuf;
      end
    end else begin
      if (dev_active) dev_last_len = dev_len;
      dev_active = 0;
      dev_beat = 0;
      mem_resp = spur_all | (spur_rand & ($urandom_range(0, 3) == 0));
      mem_rdata = {$urandom, $urandom};
    end
  end

  // Monitor: every resp pops the expected entry of that side.
  always @(negedge clk) begin
    exp_t e;
    if (i_resp | d_resp)
      chk("resp_bus_idle", !mem_read && !mem_write && !(i_resp && d_resp),
          {mem_read, mem_write, i_resp, d_resp}, 4'b0011 & {2'b00, i_resp, d_resp});
    if (i_resp) begin
      served_q.push_back(0);
      if (i_q.size() == 0) chk("i_resp_unexpected", 0, 1, 0);
      else begin
        e = i_q.pop_front();
        chk("i_rdata", i_rdata == e.data, i_rdata, e.data);
      end
    end
    if (d_resp) begin
      served_q.push_back(1);
      if (d_q.size() == 0) chk("d_resp_unexpected", 0, 1, 0);
      else begin
        e = d_q.pop_front();
        if (e.wr) chk("d_write_line", dev_line(e.addr) == e.data, dev_line(e.addr), e.data);
        else      chk("d_rdata", d_rdata == e.data, d_rdata, e.data);
      end
    end
  end

  task automatic req_i(input logic [31:0] a, output int lat);
    exp_t e;
    int t0;
    bit got;
    e.addr = {a[31:5], 5'b0};
    e.data = ref_line(e.addr);
    e.wr = 0;
    i_q.push_back(e);
    @(posedge clk); #1;
    i_read = 1'b1; i_addr = a; t0 = cyc; got = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (i_resp) got = 1;
    end
    lat = cyc - t0 + 1;
    if (!got) chk("i_resp_timeout", 0, 0, 1);
    @(posedge clk); #1;
    i_read = 1'b0; i_addr = $urandom;
  endtask

  // op: 0 read, 1 write, 2 read+write (treated as write)
  task automatic req_d(input logic [31:0] a, input int op, input logic [255:0] w,
                       input bit corrupt, output int lat);
    exp_t e;
    int t0;
    bit got;
    e.addr = {a[31:5], 5'b0};
    e.wr = (op != 0);
    if (e.wr) begin
      ref_mem[e.addr] = w;
      e.data = w;
    end else e.data = ref_line(e.addr);
    d_q.push_back(e);
    @(posedge clk); #1;
    d_read = (op != 1); d_write = (op != 0); d_addr = a; d_wdata = w;
    t0 = cyc; got = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (d_resp) got = 1;
      else if (corrupt && n == 2) begin
        d_addr = $urandom; d_wdata = rand_line();
      end
    end
    lat = cyc - t0 + 1;
    if (!got) chk("d_resp_timeout", 0, 0, 1);
    @(posedge clk); #1;
    d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic check_zero(input string name);
    chk(name, !i_resp && !d_resp && !mem_read && !mem_write && i_rdata == '0 && d_rdata == '0
              && mem_address == '0 && mem_wdata == '0,
        {i_resp, d_resp, mem_read, mem_write, |i_rdata, |d_rdata, |mem_address, |mem_wdata}, 0);
  endtask

  localparam logic [255:0] L60 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, lat2;
    int model_last;
    int first_exp;
    bit seen;
    logic [255:0] w;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_outputs");
    rst = 1'b1;

    // Single I read of a known line with zero-wait memory.
    fixed_wait = 0;
    dev_mem[32'h60] = L60;
    ref_mem[32'h60] = L60;
    req_i(32'h60, lat);
    chk("i_read_latency", lat == 6, lat, 6);
    chk("i_burst_addr", dev_last_addr == 32'h60, dev_last_addr, 32'h60);

    // D write-back of an unaligned address, inputs scrambled after grant.
    w = rand_line();
    req_d(32'h1234_5678, 1, w, 1, lat);
    chk("d_burst_addr", dev_last_addr == 32'h1234_5660, dev_last_addr, 32'h1234_5660);
    req_d(32'h1234_5660, 0, rand_line(), 0, lat);
    model_last = 1;

    // Simultaneous I and D requests, two rounds.
    fixed_wait = -1;
    for (int r = 0; r < 2; r++) begin
      served_q.delete();
`ifdef ARB_ROUND_ROBIN_EN
      first_exp = (model_last == 1) ? 0 : 1;
`else
      first_exp = 1;
`endif
      fork
        req_i(32'h1000_0000 + 32'(r * 32), lat);
        req_d(32'h2000_0000 + 32'(r * 32), 0, rand_line(), 0, lat2);
      join
      chk("tie_order_count", served_q.size() == 2, served_q.size(), 2);
      if (served_q.size() == 2) begin
        chk("tie_first", served_q[0] == first_exp, served_q[0], first_exp);
        chk("tie_second", served_q[1] == 1 - first_exp, served_q[1], 1 - first_exp);
      end
      model_last = 1 - first_exp;
    end

    // Three wait states before every beat.
    fixed_wait = 3;
    req_i(32'h1000_0040, lat);
    chk("wait_mem_read_len", dev_last_len == 16, dev_last_len, 16);
    chk("wait_latency", lat == 18, lat, 18);

    // Reset in the middle of a read burst.
    fixed_wait = 1;
    @(posedge clk); #1;
    i_read = 1'b1; i_addr = 32'h1000_0100;
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (dev_beat >= 2) seen = 1;
    end
    chk("reset_burst_reached_beat2", seen, seen, 1);
    @(posedge clk); #1;
    rst = 1'b0; i_read = 1'b0;
    @(negedge clk);
    check_zero("reset_midburst_outputs");
    @(posedge clk); #1;
    rst = 1'b1;
    model_last = 1;
    fixed_wait = 0;
    req_i(32'h1000_0120, lat);
    chk("post_reset_len", dev_last_len == 4, dev_last_len, 4);
    chk("post_reset_latency", lat == 6, lat, 6);

    // Spurious mem_resp while idle.
    spur_all = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_read || mem_write || i_resp || d_resp) seen = 1;
    end
    spur_all = 0;
    chk("spurious_idle", !seen, seen, 0);

    // Randomized concurrent traffic; I and D work in disjoint regions.
    fixed_wait = -1;
    spur_rand = 1;
    fork
      for (int k = 0; k < 20; k++) begin
        int l;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        req_i(32'h1000_0000 + 32'($urandom_range(0, 15) * 32) + 32'($urandom_range(0, 31)), l);
      end
      for (int k = 0; k < 25; k++) begin
        int l;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        req_d(32'h2000_0000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31)),
              int'($urandom_range(0, 2)), rand_line(), 0, l);
      end
    join
    spur_rand = 0;
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", i_q.size() == 0 && d_q.size() == 0, i_q.size() + d_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
